// File: rtl/scan_pkg.sv
// Shared encodings and the scan plan for the cube scan sequencer.
// Batch 0 is the reference slot, so its setup is empty.
package scan_pkg;

    localparam int MOVE_W    = 5;
    localparam int NUM_STEPS = 49;
    localparam int LAST_STEP = NUM_STEPS - 1;
    localparam int NUM_BATCH = 12;

    typedef enum logic [2:0] {
        FACE_U = 3'd0,
        FACE_L = 3'd1,
        FACE_F = 3'd2,
        FACE_R = 3'd3,
        FACE_B = 3'd4,
        FACE_D = 3'd5
    } face_e;

    typedef enum logic [1:0] {
        DIR_CW   = 2'd0,
        DIR_CCW  = 2'd1,
        DIR_HALF = 2'd2
    } dir_e;

    typedef logic [MOVE_W-1:0] move_t;

    localparam move_t END_MARK = 5'b11111;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        SETTLE    = 3'd4,
        STABLE    = 3'd5
    } state_e;

    function automatic move_t mk(input face_e f, input dir_e d);
        return {f, d};
    endfunction

    function automatic move_t inv_move(input move_t m);
        move_t r;
        r = m;
        unique case (m[1:0])
            2'd0:    r[1:0] = 2'd1;
            2'd1:    r[1:0] = 2'd0;
            default: r[1:0] = m[1:0];
        endcase
        return r;
    endfunction

    // 0..5 corner batches, 6..11 edge batches
    function automatic logic [1:0] setup_len(input logic [3:0] b);
        logic [1:0] n;
        unique case (b)
            4'd0:          n = 2'd0;
            4'd9, 4'd11:   n = 2'd2;
            4'd1, 4'd2,
            4'd3, 4'd4,
            4'd5, 4'd6,
            4'd7, 4'd8,
            4'd10:         n = 2'd1;
            default:       n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic move_t setup_move(input logic [3:0] b,
                                         input logic       i);
        move_t m;
        unique case (b)
            4'd1:    m = mk(FACE_R, DIR_CW);
            4'd2:    m = mk(FACE_R, DIR_HALF);
            4'd3:    m = mk(FACE_R, DIR_CCW);
            4'd4:    m = mk(FACE_F, DIR_CW);
            4'd5:    m = mk(FACE_F, DIR_CCW);
            4'd6:    m = mk(FACE_L, DIR_CW);
            4'd7:    m = mk(FACE_L, DIR_HALF);
            4'd8:    m = mk(FACE_B, DIR_CW);
            4'd9:    m = i ? mk(FACE_R, DIR_CW) : mk(FACE_F, DIR_CW);
            4'd10:   m = mk(FACE_D, DIR_HALF);
            4'd11:   m = i ? mk(FACE_B, DIR_HALF) : mk(FACE_L, DIR_CCW);
            default: m = END_MARK;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/scan_move_rom.sv
// Combinational move list lookup indexed by scan step and slot.
// Slot 0 is always U; then undo of the previous batch, then next setup.
module scan_move_rom
    import scan_pkg::*;
(
    input  logic [5:0] step_i,
    input  logic [3:0] slot_i,
    output move_t      move_o
);

    logic [3:0] batch;
    logic [3:0] prev;
    logic [1:0] ulen;
    logic [1:0] slen;
    logic [3:0] k;
    logic [3:0] j;
    logic       ui;

    always_comb begin
        batch  = step_i[5:2];
        prev   = batch - 4'd1;
        ulen   = setup_len(prev);
        slen   = (step_i == 6'(LAST_STEP)) ? 2'd0 : setup_len(batch);
        k      = slot_i - 4'd1;
        j      = k - {2'b00, ulen};
        // undo walks the previous setup backwards
        ui     = ulen[1] ? ~k[0] : 1'b0;
        move_o = END_MARK;
        if (step_i == 6'd0 || step_i > 6'(LAST_STEP)) begin
            move_o = END_MARK;
        end else if (slot_i == 4'd0) begin
            move_o = mk(FACE_U, DIR_CW);
        end else if (step_i[1:0] != 2'b00) begin
            move_o = END_MARK;
        end else if (k < {2'b00, ulen}) begin
            move_o = inv_move(setup_move(prev, ui));
        end else if (j < {2'b00, slen}) begin
            move_o = setup_move(batch, j[0]);
        end
    end

endmodule

// File: rtl/scan_move_sequencer.sv
// Issues the per-step cube moves to the motor driver, then waits for
// the colour sensor to settle before flagging the cube stable.
module scan_move_sequencer
    import scan_pkg::*;
#(
    parameter logic [23:0] SETTLE_CYCLES = 24'd1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send_setup_moves,
    input  logic [5:0]  counter,
    output logic [4:0]  move,
    output logic        move_valid,
    input  logic        move_ready,
    input  logic        motor_done,
    output logic        color_sensor_stable,
    output logic        busy,
    output logic        protocol_error
);

    state_e      state_q, state_d;
    logic [5:0]  step_q, step_d;
    logic [3:0]  slot_q, slot_d;
    move_t       move_q, move_d;
    logic        valid_q, valid_d;
    logic        stable_q, stable_d;
    logic        perr_q, perr_d;
    logic [23:0] cnt_q, cnt_d;
    move_t       rom_move;
    logic        busy_w;

    scan_move_rom u_rom (
        .step_i (step_q),
        .slot_i (slot_q),
        .move_o (rom_move)
    );

    assign busy_w = !(state_q == IDLE || state_q == STABLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            slot_q   <= '0;
            move_q   <= '0;
            valid_q  <= 1'b0;
            stable_q <= 1'b0;
            perr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            slot_q   <= slot_d;
            move_q   <= move_d;
            valid_q  <= valid_d;
            stable_q <= stable_d;
            perr_q   <= perr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        slot_d   = slot_q;
        move_d   = move_q;
        valid_d  = valid_q;
        stable_d = stable_q;
        perr_d   = perr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE, STABLE: begin
                if (send_setup_moves) begin
                    if (counter <= 6'(LAST_STEP)) begin
                        step_d   = counter;
                        slot_d   = '0;
                        stable_d = 1'b0;
                        state_d  = FETCH;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (rom_move == END_MARK) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    move_d  = rom_move;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (move_ready) begin
                    valid_d = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (motor_done) begin
                    slot_d  = slot_q + 4'd1;
                    state_d = FETCH;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_CYCLES) begin
                    stable_d = 1'b1;
                    state_d  = STABLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // requests while moving are dropped but remembered as misuse
        if (busy_w && send_setup_moves) begin
            perr_d = 1'b1;
        end
    end

    assign move                = move_q;
    assign move_valid          = valid_q;
    assign color_sensor_stable = stable_q;
    assign busy                = busy_w;
    assign protocol_error      = perr_q;

endmodule

// File: tb/tb_scan_move_sequencer.sv
// Directed bench for scan_move_sequencer with a move scoreboard
// and a face-turn word model that must cancel to identity.
module tb_scan_move_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       send_setup_moves;
    logic [5:0] counter;
    logic [4:0] move;
    logic       move_valid;
    logic       move_ready;
    logic       motor_done;
    logic       color_sensor_stable;
    logic       busy;
    logic       protocol_error;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    logic [4:0] cube[$];
    logic [4:0] tb_seq [12][2];
    int         tb_len [12];

    always #5 clock = ~clock;

    scan_move_sequencer #(
        .SETTLE_CYCLES (24'd4)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .send_setup_moves    (send_setup_moves),
        .counter             (counter),
        .move                (move),
        .move_valid          (move_valid),
        .move_ready          (move_ready),
        .motor_done          (motor_done),
        .color_sensor_stable (color_sensor_stable),
        .busy                (busy),
        .protocol_error      (protocol_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] inv(input logic [4:0] m);
        case (m[1:0])
            2'd0:    return {m[4:2], 2'd1};
            2'd1:    return {m[4:2], 2'd0};
            default: return m;
        endcase
    endfunction

    function automatic int qturns(input logic [1:0] d);
        return (d == 2'd0) ? 1 : (d == 2'd1) ? 3 : 2;
    endfunction

    task automatic push_expected(input int s);
        int b;
        if (s == 0) return;
        exp_q.push_back(5'b00000);
        if (s % 4 != 0) return;
        b = s / 4;
        for (int i = tb_len[b-1] - 1; i >= 0; i--)
            exp_q.push_back(inv(tb_seq[b-1][i]));
        if (s < 48)
            for (int i = 0; i < tb_len[b]; i++)
                exp_q.push_back(tb_seq[b][i]);
    endtask

    // adjacent turns of one face merge; a full word reducing to empty
    // means the cube is back at identity
    task automatic cube_apply(input logic [4:0] m);
        int q;
        logic [4:0] top;
        q = qturns(m[1:0]);
        if (cube.size() > 0) begin
            top = cube[cube.size()-1];
            if (top[4:2] == m[4:2]) begin
                void'(cube.pop_back());
                q = (q + qturns(top[1:0])) % 4;
                if (q == 1) cube.push_back({m[4:2], 2'd0});
                else if (q == 2) cube.push_back({m[4:2], 2'd2});
                else if (q == 3) cube.push_back({m[4:2], 2'd1});
                return;
            end
        end
        cube.push_back(m);
    endtask

    task automatic request(input int c);
        send_setup_moves = 1'b1;
        counter = 6'(c);
        tick();
        send_setup_moves = 1'b0;
    endtask

    task automatic service(input bit inject);
        int idle;
        int dly;
        bit done;
        bit first;
        logic [4:0] m0;
        logic [4:0] e;
        idle = 0;
        done = 0;
        first = 1;
        while (!done) begin
            if (move_valid) begin
                m0 = move;
                dly = $urandom_range(0, 3);
                repeat (dly) begin
                    tick();
                    chk("held", {move_valid, move}, {1'b1, m0});
                end
                move_ready = 1'b1;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
                chk("move", move, e);
                cube_apply(move);
                tick();
                move_ready = 1'b0;
                chk("valid_drop", move_valid, 0);
                tick();
                if (inject && first) begin
                    send_setup_moves = 1'b1;
                    counter = 6'd7;
                end
                motor_done = 1'b1;
                tick();
                motor_done = 1'b0;
                send_setup_moves = 1'b0;
                if (inject && first)
                    chk("busy_req_perr", protocol_error, 1);
                first = 0;
                idle = 0;
            end else if (color_sensor_stable) begin
                done = 1;
            end else begin
                tick();
                idle++;
                if (idle > 200) begin
                    chk("timeout", color_sensor_stable, 1);
                    done = 1;
                end
            end
        end
    endtask

    initial begin
        int n;
        bit seen;
        tb_len = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 2};
        tb_seq = '{'{5'b11111, 5'b11111}, '{5'b01100, 5'b11111},
                   '{5'b01110, 5'b11111}, '{5'b01101, 5'b11111},
                   '{5'b01000, 5'b11111}, '{5'b01001, 5'b11111},
                   '{5'b00100, 5'b11111}, '{5'b00110, 5'b11111},
                   '{5'b10000, 5'b11111}, '{5'b01000, 5'b01100},
                   '{5'b10110, 5'b11111}, '{5'b00101, 5'b10010}};
        reset = 1'b1;
        send_setup_moves = 1'b0;
        counter = '0;
        move_ready = 1'b0;
        motor_done = 1'b0;
        repeat (2) tick();
        chk("rst_valid", move_valid, 0);
        chk("rst_move", move, 0);
        chk("rst_stable", color_sensor_stable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", protocol_error, 0);
        reset = 1'b0;
        tick();

        request(0);
        chk("s0_busy", busy, 1);
        n = 0;
        seen = 0;
        while (!color_sensor_stable && n < 50) begin
            if (move_valid) seen = 1;
            tick();
            n++;
        end
        chk("s0_no_valid", seen, 0);
        chk("s0_latency", n, 6);

        request(50);
        chk("oor_perr", protocol_error, 1);
        chk("oor_stable_kept", color_sensor_stable, 1);
        chk("oor_busy", busy, 0);
        seen = 0;
        repeat (5) begin
            tick();
            if (move_valid || busy) seen = 1;
        end
        chk("oor_quiet", seen, 0);

        #2 reset = 1'b1;
        #1;
        chk("perr_cleared", protocol_error, 0);
        chk("stable_cleared", color_sensor_stable, 0);
        tick();
        reset = 1'b0;
        tick();

        cube.delete();
        for (int s = 0; s <= 48; s++) begin
            push_expected(s);
            request(s);
            chk("stable_drop", color_sensor_stable, 0);
            service(1'b0);
            chk("stable_rise", color_sensor_stable, 1);
            chk("drained", exp_q.size(), 0);
        end
        chk("cube_identity", cube.size(), 0);
        chk("perr_clean", protocol_error, 0);

        push_expected(4);
        request(4);
        service(1'b1);
        chk("inject_drained", exp_q.size(), 0);
        chk("inject_perr", protocol_error, 1);

        request(4);
        n = 0;
        while (!move_valid && n < 20) begin
            tick();
            n++;
        end
        chk("pre_rst_valid", move_valid, 1);
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", move_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_move", move, 0);
        chk("arst_perr", protocol_error, 0);
        chk("arst_stable", color_sensor_stable, 0);
        tick();
        reset = 1'b0;
        tick();
        motor_done = 1'b1;
        tick();
        motor_done = 1'b0;
        seen = 0;
        repeat (20) begin
            tick();
            if (move_valid || busy || color_sensor_stable) seen = 1;
        end
        chk("late_done_quiet", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
